// File: rtl/lut_conf_pkg.sv
// lut_conf_pkg: shared types and constants for the LUT configuration writer.
//   conf_state_t : writer FSM states
//   total_bits() : number of config bits in one frame for a chain
//   CRC_POLY     : CRC-8 generator polynomial (x^8 + x^2 + x + 1)
package lut_conf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SHIFT,
        COMMIT
    } conf_state_t;

    localparam logic [7:0] CRC_POLY = 8'h07;

    function automatic int total_bits(input int inputs, input int chain_len);
        return chain_len * (1 << inputs);
    endfunction

endpackage

// File: rtl/lut_conf_crc8.sv
// lut_conf_crc8: serial CRC-8 (MSB-first feedback) over the bits shifted into the chain.
//   clock, reset : clock and asynchronous active-high reset
//   clr_i        : clear the CRC to 0x00 (frame start)
//   en_i         : fold bit_i into the CRC this cycle
//   bit_i        : serial data bit
//   crc_o        : current CRC value (registered)
// Only built when LUT_CONF_CRC_EN is defined.
`ifdef LUT_CONF_CRC_EN
module lut_conf_crc8
    import lut_conf_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;
    logic       fb;

    assign fb    = crc_q[7] ^ bit_i;
    assign crc_d = clr_i ? 8'h00 :
                   en_i  ? ({crc_q[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00)) : crc_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) crc_q <= 8'h00;
        else       crc_q <= crc_d;
    end

    assign crc_o = crc_q;

endmodule
`endif

// File: rtl/lut_conf_writer.sv
// lut_conf_writer: byte stream to serial LUT configuration chain writer.
//   clock, reset  : clock and asynchronous active-high reset
//   start         : begin a frame (honoured only when idle)
//   conf_data     : configuration byte, bits shifted out LSB first
//   conf_valid    : conf_data is valid
//   conf_ready    : a byte is accepted this cycle
//   chain_bit     : serial data to the chain head
//   chain_shift   : chain captures chain_bit when high
//   chain_commit  : one-cycle strobe after the last bit of a frame
//   busy          : a frame is in progress
//   crc           : CRC-8 of the shifted bits (only with LUT_CONF_CRC_EN)
// Optional feature macro: LUT_CONF_CRC_EN.
module lut_conf_writer
    import lut_conf_pkg::*;
#(
    parameter int INPUTS    = 2,
    parameter int CHAIN_LEN = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] conf_data,
    input  logic       conf_valid,
    output logic       conf_ready,
    output logic       chain_bit,
    output logic       chain_shift,
    output logic       chain_commit,
    output logic       busy
`ifdef LUT_CONF_CRC_EN
    ,
    output logic [7:0] crc
`endif
);

    localparam int TOTAL = total_bits(INPUTS, CHAIN_LEN);
    localparam int CW    = $clog2(TOTAL + 1);
    // remaining counter widened to at least 4 bits so it can be compared against 8
    localparam int RW    = (CW < 4) ? 4 : CW;

    conf_state_t   state_q;
    logic [CW-1:0] rem_q;
    logic [3:0]    burst_q;
    logic [7:0]    shreg_q;
    logic          ready_q;
    logic          bit_q;
    logic          shift_q;
    logic          commit_q;
    logic          busy_q;
    logic [RW-1:0] rem_x;
    logic [3:0]    burst_d;

    assign rem_x   = RW'(rem_q);
    assign burst_d = (rem_x >= RW'(8)) ? 4'd8 : rem_x[3:0];

    // Outputs are registered from the next state, so each output already
    // reflects the state the FSM is entering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            burst_q  <= '0;
            shreg_q  <= '0;
            ready_q  <= 1'b0;
            bit_q    <= 1'b0;
            shift_q  <= 1'b0;
            commit_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rem_q   <= CW'(TOTAL);
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (conf_valid && ready_q) begin
                        shreg_q <= conf_data;
                        burst_q <= burst_d;
                        ready_q <= 1'b0;
                        shift_q <= 1'b1;
                        bit_q   <= conf_data[0];
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg_q <= shreg_q >> 1;
                    rem_q   <= rem_q - CW'(1);
                    burst_q <= burst_q - 4'd1;
                    if (burst_q == 4'd1) begin
                        shift_q <= 1'b0;
                        bit_q   <= 1'b0;
                        if (rem_q == CW'(1)) begin
                            commit_q <= 1'b1;
                            state_q  <= COMMIT;
                        end else begin
                            ready_q <= 1'b1;
                            state_q <= WAIT;
                        end
                    end else begin
                        // next bit to present is the one after the current LSB
                        bit_q <= shreg_q[1];
                    end
                end
                COMMIT: begin
                    commit_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign conf_ready   = ready_q;
    assign chain_bit    = bit_q;
    assign chain_shift  = shift_q;
    assign chain_commit = commit_q;
    assign busy         = busy_q;

`ifdef LUT_CONF_CRC_EN
    lut_conf_crc8 u_crc (
        .clock (clock),
        .reset (reset),
        .clr_i (state_q == IDLE && start),
        .en_i  (shift_q),
        .bit_i (bit_q),
        .crc_o (crc)
    );
`endif

endmodule

// File: tb/tb_lut_conf_writer.sv
// tb_lut_conf_writer: self-checking bench for lut_conf_writer on three chain sizes (12, 4 and 8 bits).
module tb_lut_conf_writer;

    localparam int TOT [3] = '{12, 4, 8};

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] start;
    logic [7:0] conf_data;
    logic       conf_valid;
    logic       ready_v  [3];
    logic       bit_v    [3];
    logic       shift_v  [3];
    logic       commit_v [3];
    logic       busy_v   [3];
`ifdef LUT_CONF_CRC_EN
    logic [7:0] crc_v    [3];
    logic [7:0] crc_at   [3];
`endif

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          n [3];
    int          commits [3];
    int          ready_cnt [3];
    int          last_shift [3];
    int          commit_cyc [3];
    logic [31:0] got [3];
    logic [7:0]  b [4];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        lut_conf_writer #(
            .INPUTS   ((g == 2) ? 3 : 2),
            .CHAIN_LEN((g == 0) ? 3 : 1)
        ) dut (
            .clock        (clock),
            .reset        (reset),
            .start        (start[g]),
            .conf_data    (conf_data),
            .conf_valid   (conf_valid),
            .conf_ready   (ready_v[g]),
            .chain_bit    (bit_v[g]),
            .chain_shift  (shift_v[g]),
            .chain_commit (commit_v[g]),
            .busy         (busy_v[g])
`ifdef LUT_CONF_CRC_EN
            ,
            .crc          (crc_v[g])
`endif
        );
    end

    always @(negedge clock) begin
        for (int s = 0; s < 3; s++) begin
            if (shift_v[s]) begin
                if (n[s] < 32) got[s][n[s]] = bit_v[s];
                n[s]++;
                last_shift[s] = cyc;
            end
            if (commit_v[s]) begin
                commits[s]++;
                commit_cyc[s] = cyc;
`ifdef LUT_CONF_CRC_EN
                crc_at[s] = crc_v[s];
`endif
            end
            if (ready_v[s]) ready_cnt[s]++;
        end
    end

    // Reference: the frame is the byte stream read LSB first, cut at the frame length.
    function automatic logic [31:0] model_bits(input logic [7:0] bb [4], input int total);
        logic [31:0] v = '0;
        for (int i = 0; i < total; i++) v[i] = bb[i / 8][i % 8];
        return v;
    endfunction

`ifdef LUT_CONF_CRC_EN
    function automatic logic [7:0] model_crc(input logic [31:0] bits, input int total);
        logic [7:0] c = 8'h00;
        for (int i = 0; i < total; i++) c = {c[6:0], 1'b0} ^ ((c[7] ^ bits[i]) ? 8'h07 : 8'h00);
        return c;
    endfunction
`endif

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic frame(input int s, input logic [7:0] bb [4], input bit hold, input bit stall, input bit poke);
        int nb;
        int acc;
        logic ok;
        nb = (TOT[s] + 7) / 8;
        acc = 0;
        n[s] = 0;
        got[s] = '0;
        commits[s] = 0;
        ready_cnt[s] = 0;
        start[s] = 1'b1;
        step();
        start[s] = 1'b0;
        chk("ready_after_start", 32'(ready_v[s]), 1);
        chk("busy_after_start", 32'(busy_v[s]), 1);
`ifdef LUT_CONF_CRC_EN
        chk("crc_cleared", 32'(crc_v[s]), 0);
`endif
        if (stall) begin
            for (int t = 0; t < 5; t++) begin
                chk("stall_no_shift", 32'(shift_v[s]), 0);
                chk("stall_busy", 32'(busy_v[s]), 1);
                step();
            end
        end
        for (int k = 0; k < nb; k++) begin
            if (!hold) begin
                conf_valid = 1'b0;
                repeat ($urandom_range(0, 3)) step();
            end
            conf_data = bb[k];
            conf_valid = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 40 && !ok; t++) begin
                ok = ready_v[s];
                if (k == 0) acc = cyc;
                step();
            end
            chk("accept", 32'(ok), 1);
            if (poke && k == 0) begin
                start[s] = 1'b1;
                step();
                start[s] = 1'b0;
            end
        end
        conf_valid = 1'b0;
        for (int t = 0; t < 60 && commits[s] == 0; t++) step();
        chk("commit_seen", commits[s], 1);
        chk("busy_drop", 32'(busy_v[s]), 0);
        chk("commit_pulse", 32'(commit_v[s]), 0);
        chk("ready_after_commit", 32'(ready_v[s]), 0);
        chk("nbits", n[s], TOT[s]);
        chk("bits", got[s], model_bits(bb, TOT[s]));
        chk("commit_after_last", commit_cyc[s], last_shift[s] + 1);
        if (hold) begin
            chk("latency", commit_cyc[s] - acc, TOT[s] + nb);
            chk("ready_cycles", ready_cnt[s], nb);
        end
`ifdef LUT_CONF_CRC_EN
        chk("crc_at_commit", 32'(crc_at[s]), 32'(model_crc(model_bits(bb, TOT[s]), TOT[s])));
        chk("crc_hold", 32'(crc_v[s]), 32'(model_crc(model_bits(bb, TOT[s]), TOT[s])));
`endif
    endtask

    initial begin
        reset = 1'b1;
        start = '0;
        conf_data = '0;
        conf_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            n[s] = 0;
            commits[s] = 0;
            ready_cnt[s] = 0;
            got[s] = '0;
        end
        step();
        step();
        chk("rst_ready", 32'(ready_v[0]), 0);
        chk("rst_bit", 32'(bit_v[0]), 0);
        chk("rst_shift", 32'(shift_v[0]), 0);
        chk("rst_commit", 32'(commit_v[0]), 0);
        chk("rst_busy", 32'(busy_v[0]), 0);
`ifdef LUT_CONF_CRC_EN
        chk("rst_crc", 32'(crc_v[0]), 0);
`endif
        reset = 1'b0;
        step();

        b = '{8'hA6, 8'h00, 8'h00, 8'h00};
        frame(1, b, 1'b1, 1'b0, 1'b0);
        chk("a6_sequence", 32'(got[1][3:0]), 32'h6);

        b = '{8'h5A, 8'h03, 8'h00, 8'h00};
        frame(0, b, 1'b1, 1'b0, 1'b0);
        chk("5a03_sequence", 32'(got[0][11:0]), 32'h35A);

        foreach (b[i]) b[i] = 8'($urandom);
        frame(0, b, 1'b0, 1'b1, 1'b1);

        n[0] = 0;
        commits[0] = 0;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        conf_data = 8'($urandom);
        conf_valid = 1'b1;
        step();
        conf_valid = 1'b0;
        step();
        step();
        step();
        chk("shifts_before_reset", n[0], 3);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(ready_v[0]), 0);
        chk("mid_rst_bit", 32'(bit_v[0]), 0);
        chk("mid_rst_shift", 32'(shift_v[0]), 0);
        chk("mid_rst_commit", 32'(commit_v[0]), 0);
        chk("mid_rst_busy", 32'(busy_v[0]), 0);
`ifdef LUT_CONF_CRC_EN
        chk("mid_rst_crc", 32'(crc_v[0]), 0);
`endif
        step();
        step();
        reset = 1'b0;
        repeat (20) step();
        chk("no_commit_after_reset", commits[0], 0);
        chk("idle_after_reset", 32'(busy_v[0]), 0);

        foreach (b[i]) b[i] = 8'($urandom);
        frame(0, b, 1'b1, 1'b0, 1'b0);

        b = '{8'hFF, 8'h00, 8'h00, 8'h00};
        frame(2, b, 1'b1, 1'b0, 1'b0);
        foreach (b[i]) b[i] = 8'($urandom);
        frame(2, b, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            foreach (b[i]) b[i] = 8'($urandom);
            frame(int'($urandom_range(0, 2)), b, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lut_conf_writer.md
# lut_conf_writer

Serial configuration writer for the `Lut` configuration chain. It accepts configuration bytes over a valid/ready stream from the pad interface and shifts exactly `CHAIN_LEN * 2**INPUTS` bits into the chain, LSB first. When the frame is complete it pulses a commit strobe. It sits between the byte-wide IO inputs and one or more chained `Lut` instances, on the transmit side of the LUT configuration interface.

## Interface
Parameters:
- `INPUTS`, 2: LUT input count; each LUT holds `2**INPUTS` config bits.
- `CHAIN_LEN`, 1: number of LUTs daisy-chained on one configuration line.

Ports:
- `clock`  in  1  single clock for the block; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a new frame; sampled only in IDLE.
- `conf_data`  in  8  configuration byte.
- `conf_valid`  in  1  `conf_data` is valid.
- `conf_ready`  out  1  block accepts a byte this cycle.
- `chain_bit`  out  1  serial data to the chain head.
- `chain_shift`  out  1  chain shift enable; the chain captures `chain_bit` when this is high.
- `chain_commit`  out  1  one-cycle strobe after the last bit; the chain copies its shadow register to the active LUT.
- `busy`  out  1  a frame is in progress.
- `crc`  out  8  CRC-8 over shifted bits. Present only with `LUT_CONF_CRC_EN`.

## Operation
- `TOTAL_BITS = CHAIN_LEN * 2**INPUTS`. The bit counter width is `$clog2(TOTAL_BITS+1)`.
- States:
  - IDLE:
    - `start` high: load the remaining counter with TOTAL_BITS and go to WAIT.
    - `start` low: stay in IDLE.
  - WAIT:
    - `conf_ready` = 1.
    - On `conf_valid && conf_ready`: latch `conf_data` into an 8-bit shift register. Set `burst = min(8, remaining)` and go to SHIFT.
  - SHIFT:
    - `chain_shift` = 1 and `chain_bit` = `shreg[0]`.
    - Each cycle: shift right, decrement `remaining` and `burst`.
    - When `burst` reaches 0:
      - `remaining` = 0: go to COMMIT.
      - Otherwise: go to WAIT.
  - COMMIT:
    - `chain_commit` = 1 for one cycle, then go to IDLE.
- `busy` = 1 in WAIT, SHIFT and COMMIT.
- Byte bits beyond `remaining` in the final byte are discarded and never shifted.
- `start` outside IDLE is ignored.
- `conf_valid` outside WAIT is not acknowledged (`conf_ready` = 0).
- A held `conf_valid` with stable data is accepted exactly once per WAIT visit.
- Outside SHIFT, `chain_bit` is driven 0.

## Timing
- Reset values: `conf_ready`=0, `chain_bit`=0, `chain_shift`=0, `chain_commit`=0, `busy`=0, `crc`=0x00, state IDLE. All outputs are registered.
- `start` in cycle N: `busy` and `conf_ready` are high in cycle N+1.
- Byte accepted in cycle N: `chain_shift` is high for cycles N+1 .. N+burst.
- `conf_ready` returns high in cycle N+burst+1 (one bubble cycle per byte).
- After the last bit shifts in cycle M: `chain_commit` is high in M+1, and `busy` drops in M+2.
- Full frame minimum latency from accepting the first byte to commit: `TOTAL_BITS + ceil(TOTAL_BITS/8)` cycles.
- Reset asserted mid-frame: the block returns to IDLE immediately. No commit is issued. Partial chain contents are left as-is; the next full frame overwrites them.

## Configuration
- `LUT_CONF_CRC_EN` defined:
  - An 8-bit CRC register, polynomial 0x07, is cleared on `start` accept.
  - It updates with `chain_bit` on every `chain_shift` cycle (MSB-first feedback).
  - `crc` is valid from the cycle of `chain_commit` until the next `start` accept.
- `LUT_CONF_CRC_EN` undefined: no CRC logic and no `crc` port.

## Structure
- Shared package `lut_conf_pkg` contains:
  - state enum `conf_state_t` (IDLE, WAIT, SHIFT, COMMIT);
  - localparam function for `TOTAL_BITS`;
  - CRC-8 polynomial constant.
- One natural sub-module: `lut_conf_crc8`, a serial CRC-8 update instantiated only under `LUT_CONF_CRC_EN`.
- The FSM, counters and shift register stay in the top module.

## Test plan
- INPUTS=2, CHAIN_LEN=1:
  - Stimulus: `start`, then byte 0xA6.
  - Required: `chain_bit` = 0,1,1,0 on 4 consecutive `chain_shift` cycles; then `chain_commit` for one cycle; `conf_ready` never reasserts.
- INPUTS=2, CHAIN_LEN=3:
  - Stimulus: bytes 0x5A and 0x03, with `conf_valid` held high.
  - Required: 8 shifts of 0,1,0,1,1,0,1,0; one-cycle `conf_ready` gap; 4 shifts of 1,1,0,0; commit 1 cycle after the 12th shift.
- Handshake:
  - Stimulus: `conf_valid` low for 5 cycles in WAIT.
  - Required: `chain_shift` stays 0 and `busy` stays 1.
  - Stimulus: `start` pulsed during SHIFT.
  - Required: no effect on the counter or the bit sequence.
- Reset mid-frame:
  - Stimulus: assert `reset` after 3 shifts of a 12-bit frame, with no clock edge.
  - Required: all outputs 0 immediately; no `chain_commit`.
  - Follow-up: a new full frame commits normally.
- With `LUT_CONF_CRC_EN`, INPUTS=3, CHAIN_LEN=1:
  - Stimulus: frame 0xFF.
  - Required: `crc` equals the CRC-8/0x07 of the 8 bits as shifted (LSB of 0xFF first), computed by a bench reference model.
  - Follow-up: the next `start` clears `crc` to 0x00.
